// File: rtl/uart_tx_peripheral.sv
// Memory-mapped 8N1 UART transmitter on the GPIO slot of the data bus.
// Core writes are queued in a small circular FIFO and shifted out LSB first.
module uart_tx_peripheral #(
  parameter int unsigned BAUD_DIV   = 434,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [31:0] TX_ADDR    = 32'h1001_0024,
  parameter logic [31:0] STAT_ADDR  = 32'h1001_0028
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Adr_in,
  input  logic [2:0]  selector_in,
  input  logic        MemWrite_in,
  input  logic        MemRead_in,
  input  logic [31:0] WriteData_in,
  output logic [31:0] Data_out,
  output logic        tx,
  output logic        tx_busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [15:0] BAUD_M1 = 16'(BAUD_DIV - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t      r_state, w_state_n;
  logic [15:0] r_baud, w_baud_n;
  logic [2:0]  r_idx, w_idx_n;
  logic [7:0]  r_shift, w_shift_n;
  logic        w_tx_n;

  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [CW-1:0] r_count;
  logic          r_overflow;
  logic [7:0]    r_last;

  logic w_sel, w_wr_tx, w_wr_st, w_rd;
  logic w_empty, w_full, w_push, w_pop;
  logic [3:0] w_cnt4;
  logic w_unused_wd;

  assign w_sel   = (selector_in == 3'b010);
  assign w_wr_tx = w_sel & MemWrite_in & (Adr_in == TX_ADDR);
  assign w_wr_st = w_sel & MemWrite_in & (Adr_in == STAT_ADDR);
  assign w_rd    = w_sel & MemRead_in;
  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CW'(FIFO_DEPTH));
  // A full FIFO can still take a byte when the FSM frees a slot this cycle
  assign w_push  = w_wr_tx & (~w_full | w_pop);
  assign w_cnt4  = 4'(r_count);
  assign tx_busy = (r_state != IDLE);
  assign w_unused_wd = ^WriteData_in[31:8];

  always_comb begin
    Data_out = 32'h0;
    if (w_rd && Adr_in == TX_ADDR)
      Data_out = {24'b0, r_last};
    else if (w_rd && Adr_in == STAT_ADDR)
      Data_out = {24'b0, w_cnt4, r_overflow, tx_busy, w_full, w_empty};
  end

  always_comb begin
    w_state_n = r_state;
    w_baud_n  = r_baud;
    w_idx_n   = r_idx;
    w_shift_n = r_shift;
    w_pop     = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_pop     = 1'b1;
          w_shift_n = r_mem[r_rp];
          w_baud_n  = BAUD_M1;
          w_state_n = START;
        end
      end
      START: begin
        if (r_baud == 16'd0) begin
          w_baud_n  = BAUD_M1;
          w_idx_n   = 3'd0;
          w_state_n = DATA;
        end else begin
          w_baud_n = r_baud - 16'd1;
        end
      end
      DATA: begin
        if (r_baud == 16'd0) begin
          w_shift_n = {1'b0, r_shift[7:1]};
          w_idx_n   = r_idx + 3'd1;
          w_baud_n  = BAUD_M1;
          if (r_idx == 3'd7) w_state_n = STOP;
        end else begin
          w_baud_n = r_baud - 16'd1;
        end
      end
      STOP: begin
        if (r_baud == 16'd0) begin
          if (!w_empty) begin
            w_pop     = 1'b1;
            w_shift_n = r_mem[r_rp];
            w_baud_n  = BAUD_M1;
            w_state_n = START;
          end else begin
            w_state_n = IDLE;
          end
        end else begin
          w_baud_n = r_baud - 16'd1;
        end
      end
    endcase
    // Line level follows the state being entered, so tx is glitch-free
    unique case (w_state_n)
      START:   w_tx_n = 1'b0;
      DATA:    w_tx_n = w_shift_n[0];
      default: w_tx_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_baud     <= 16'd0;
      r_idx      <= 3'd0;
      r_shift    <= 8'd0;
      tx         <= 1'b1;
      r_wp       <= '0;
      r_rp       <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_last     <= 8'd0;
    end else begin
      r_state <= w_state_n;
      r_baud  <= w_baud_n;
      r_idx   <= w_idx_n;
      r_shift <= w_shift_n;
      tx      <= w_tx_n;
      if (w_push) begin
        r_wp   <= r_wp + 1'b1;
        r_last <= WriteData_in[7:0];
      end
      if (w_pop) r_rp <= r_rp + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_wr_tx && !w_push)
        r_overflow <= 1'b1;
      else if (w_wr_st && WriteData_in[0])
        r_overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp] <= WriteData_in[7:0];
  end

endmodule

// File: tb/tb_uart_tx_peripheral.sv
// Directed bench for uart_tx_peripheral with a short baud divisor.
// Frames are checked cycle by cycle against the expected 8N1 bit pattern.
module tb_uart_tx_peripheral;

  localparam int BD = 4;
  localparam logic [31:0] TXA = 32'h1001_0024;
  localparam logic [31:0] STA = 32'h1001_0028;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] Adr_in = '0;
  logic [2:0]  selector_in = '0;
  logic        MemWrite_in = 1'b0;
  logic        MemRead_in = 1'b0;
  logic [31:0] WriteData_in = '0;
  logic [31:0] Data_out;
  logic        tx, tx_busy;

  int total = 0;
  int bad = 0;
  logic [31:0] d;

  uart_tx_peripheral #(
    .BAUD_DIV(BD), .FIFO_DEPTH(4), .TX_ADDR(TXA), .STAT_ADDR(STA)
  ) dut (
    .clk(clk), .reset(reset), .Adr_in(Adr_in),
    .selector_in(selector_in), .MemWrite_in(MemWrite_in),
    .MemRead_in(MemRead_in), .WriteData_in(WriteData_in),
    .Data_out(Data_out), .tx(tx), .tx_busy(tx_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] v);
    selector_in  = 3'b010;
    Adr_in       = a;
    WriteData_in = v;
    MemWrite_in  = 1'b1;
    @(posedge clk); #1;
    MemWrite_in  = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] v);
    selector_in = 3'b010;
    Adr_in      = a;
    MemRead_in  = 1'b1;
    #1;
    v = Data_out;
    MemRead_in  = 1'b0;
  endtask

  // Sample i is taken just after edge start+1+i; skip covers samples already passed
  task automatic frame(input logic [7:0] b, input int skip);
    logic [9:0] f;
    f = {1'b1, b, 1'b0};
    for (int i = skip; i < 10 * BD; i++) begin
      @(posedge clk); #1;
      chk($sformatf("tx %h s%0d", b, i), {31'b0, tx}, {31'b0, f[i/BD]});
      chk($sformatf("busy %h s%0d", b, i), {31'b0, tx_busy}, 32'h1);
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst tx", {31'b0, tx}, 32'h1);
    chk("rst busy", {31'b0, tx_busy}, 32'h0);
    rd(STA, d); chk("rst stat", d, 32'h1);
    rd(TXA, d); chk("rst last", d, 32'h0);

    // single byte
    @(posedge clk); #1;
    wr(TXA, 32'hFFFF_FFA5);
    chk("pre-start tx", {31'b0, tx}, 32'h1);
    rd(TXA, d); chk("last a5", d, 32'h0000_00A5);
    rd(STA, d); chk("stat 1 queued", d, 32'h10);
    frame(8'hA5, 0);
    @(posedge clk); #1;
    chk("a5 idle busy", {31'b0, tx_busy}, 32'h0);
    chk("a5 idle tx", {31'b0, tx}, 32'h1);

    // back-to-back frames behind a running one
    repeat (3) @(posedge clk); #1;
    wr(TXA, 32'h33);
    wr(TXA, 32'h55);
    wr(TXA, 32'h0F);
    rd(STA, d); chk("b2b stat cnt2", d, 32'h24);
    frame(8'h33, 2);
    @(posedge clk); #1;
    chk("b2b 55 start", {31'b0, tx}, 32'h0);
    rd(STA, d); chk("b2b stat cnt1", d, 32'h14);
    frame(8'h55, 1);
    @(posedge clk); #1;
    chk("b2b 0f start", {31'b0, tx}, 32'h0);
    rd(STA, d); chk("b2b stat cnt0", d, 32'h05);
    frame(8'h0F, 1);
    @(posedge clk); #1;
    chk("b2b idle busy", {31'b0, tx_busy}, 32'h0);

    // overflow and pointer wrap
    repeat (2) @(posedge clk); #1;
    for (int k = 1; k <= 6; k++) wr(TXA, 32'(k));
    rd(STA, d); chk("ovf stat", d, 32'h4E);
    rd(TXA, d); chk("ovf last", d, 32'h05);
    wr(STA, 32'h1);
    rd(STA, d); chk("ovf cleared", d, 32'h46);
    frame(8'h01, 6);
    for (int k = 2; k <= 5; k++) frame(8'(k), 0);
    @(posedge clk); #1;
    chk("ovf idle busy", {31'b0, tx_busy}, 32'h0);
    rd(STA, d); chk("ovf drained", d, 32'h01);

    // decode guard
    selector_in = 3'b100; Adr_in = TXA;
    WriteData_in = 32'h77; MemWrite_in = 1'b1;
    @(posedge clk); #1;
    selector_in = 3'b010; MemWrite_in = 1'b0;
    @(posedge clk); #1;
    rd(STA, d); chk("guard sel stat", d, 32'h01);
    @(posedge clk); #1;
    chk("guard tx", {31'b0, tx}, 32'h1);
    chk("guard busy", {31'b0, tx_busy}, 32'h0);
    rd(TXA, d); chk("guard last", d, 32'h05);
    rd(32'h1001_002C, d); chk("unmapped rd", d, 32'h0);
    selector_in = 3'b100; Adr_in = STA; MemRead_in = 1'b1; #1;
    chk("rd bad sel", Data_out, 32'h0);
    selector_in = 3'b010; MemRead_in = 1'b0; #1;
    chk("rd no strobe", Data_out, 32'h0);

    // reset during data bit 3 with two bytes queued
    @(posedge clk); #1;
    wr(TXA, 32'h11);
    wr(TXA, 32'h22);
    wr(TXA, 32'h33);
    rd(STA, d); chk("mid stat", d, 32'h24);
    repeat (16) @(posedge clk);
    #3;
    chk("mid bit3 low", {31'b0, tx}, 32'h0);
    reset = 1'b1;
    #1;
    chk("mid rst tx", {31'b0, tx}, 32'h1);
    chk("mid rst busy", {31'b0, tx_busy}, 32'h0);
    rd(STA, d); chk("mid rst stat", d, 32'h01);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (20) @(posedge clk); #1;
    chk("post rst tx", {31'b0, tx}, 32'h1);
    chk("post rst busy", {31'b0, tx_busy}, 32'h0);
    rd(STA, d); chk("post rst stat", d, 32'h01);
    rd(TXA, d); chk("post rst last", d, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
